dm_port_arbiter: RTL

Two-master arbiter and sequencer in front of the data memory (DM). It arbitrates between master 0 (CPU MEM stage) and master 1 (DMA/debug bridge), registers the winning command, and drives DM for exactly one cycle per command. It returns the read data with a single-cycle acknowledge and suppresses misaligned accesses. It sits between the pipeline/bridge and DM, and DM's A/DMWr/DMOp/WD/pc/RD connect directly to its dm_* ports.

---
 rtl/dm_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-master arbiter and sequencer in front of the data memory (DM).
//
// Master 0 (CPU MEM stage) and master 1 (DMA/debug bridge) compete for DM. The winning
// command is registered at the accept edge and drives DM for exactly one execute cycle.
// During that cycle the owning master receives a single-cycle ack together with the
// read data. Misaligned word/halfword accesses are suppressed and flagged with err.
//
// Parameters
//   FIXED_PRIO   0 = round-robin between masters, 1 = master 0 always wins
//   CHECK_ALIGN  1 = suppress misaligned word/halfword accesses, 0 = forward everything
//   DMOP_LEN     width of the DM op field (matches `DMOp_len of the DM)
//
// Ports (N = 0, 1)
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   mN_req               command valid, held until mN_gnt is seen high
//   mN_addr/wr/op/wd/pc  command: byte address, store flag, op, store/merge data, pc tag
//   mN_gnt               combinational grant: command accepted at this rising edge
//   mN_ack/err/rd        execute-cycle pulse, misalignment flag, load result
//   dm_A/DMWr/DMOp/WD/pc registered command towards DM
//   dm_RD                DM combinational read data
module dm_port_arbiter #(
    parameter bit          FIXED_PRIO  = 1'b0,
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter int unsigned DMOP_LEN    = 3
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_req,
    input  logic [31:0]         m0_addr,
    input  logic                m0_wr,
    input  logic [DMOP_LEN-1:0] m0_op,
    input  logic [31:0]         m0_wd,
    input  logic [31:0]         m0_pc,
    output logic                m0_gnt,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [31:0]         m0_rd,

    input  logic                m1_req,
    input  logic [31:0]         m1_addr,
    input  logic                m1_wr,
    input  logic [DMOP_LEN-1:0] m1_op,
    input  logic [31:0]         m1_wd,
    input  logic [31:0]         m1_pc,
    output logic                m1_gnt,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [31:0]         m1_rd,

    output logic [31:0]         dm_A,
    output logic                dm_DMWr,
    output logic [DMOP_LEN-1:0] dm_DMOp,
    output logic [31:0]         dm_WD,
    output logic [31:0]         dm_pc,
    input  logic [31:0]         dm_RD
);

    // DM op encoding (DM_w/h/hu/b/bu/l/r, same order as the DM's definitions)
    localparam logic [DMOP_LEN-1:0] DM_W  = DMOP_LEN'(0);
    localparam logic [DMOP_LEN-1:0] DM_H  = DMOP_LEN'(1);
    localparam logic [DMOP_LEN-1:0] DM_HU = DMOP_LEN'(2);

    function automatic logic misaligned(input logic [DMOP_LEN-1:0] op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (op == DM_W) begin
            bad = (lo != 2'b00);
        end else if (op == DM_H || op == DM_HU) begin
            bad = lo[0];
        end
        return bad;
    endfunction

    // Command register and round-robin pointer
    logic                valid_q;
    logic                sel_q;
    logic [31:0]         addr_q;
    logic                wr_q;
    logic [DMOP_LEN-1:0] op_q;
    logic [31:0]         wd_q;
    logic [31:0]         pc_q;
    logic                err_q;
    logic                fav_q;

    logic                pick_m1;
    logic                accept;
    logic [31:0]         addr_d;
    logic                wr_d;
    logic [DMOP_LEN-1:0] op_d;
    logic [31:0]         wd_d;
    logic [31:0]         pc_d;
    logic                err_d;
    logic [31:0]         rd_exec;

    // Grant: a lone requester wins; under contention fav wins unless priority is fixed.
    always_comb begin
        pick_m1 = 1'b0;
        if (m1_req && !m0_req) begin
            pick_m1 = 1'b1;
        end else if (m1_req && m0_req && !FIXED_PRIO && fav_q) begin
            pick_m1 = 1'b1;
        end
        m0_gnt = !reset && m0_req && !pick_m1;
        m1_gnt = !reset && pick_m1;
        accept = m0_gnt || m1_gnt;
    end

    always_comb begin
        addr_d = m1_gnt ? m1_addr : m0_addr;
        wr_d   = m1_gnt ? m1_wr   : m0_wr;
        op_d   = m1_gnt ? m1_op   : m0_op;
        wd_d   = m1_gnt ? m1_wd   : m0_wd;
        pc_d   = m1_gnt ? m1_pc   : m0_pc;
        err_d  = CHECK_ALIGN && misaligned(op_d, addr_d[1:0]);
    end

    // Only valid tracks idle cycles; the payload holds so dm_* keep their last values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            op_q    <= '0;
            wd_q    <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            fav_q   <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                sel_q  <= m1_gnt;
                addr_q <= addr_d;
                wr_q   <= wr_d;
                op_q   <= op_d;
                wd_q   <= wd_d;
                pc_q   <= pc_d;
                err_q  <= err_d;
                fav_q  <= !m1_gnt;
            end
        end
    end

    // Execute cycle. dm_DMWr is derived from valid_q so it drops as soon as reset hits.
    always_comb begin
        dm_A    = addr_q;
        dm_DMOp = op_q;
        dm_WD   = wd_q;
        dm_pc   = pc_q;
        dm_DMWr = valid_q && wr_q && !err_q;
        rd_exec = (wr_q || err_q) ? 32'h0 : dm_RD;
        m0_ack  = valid_q && !sel_q;
        m1_ack  = valid_q && sel_q;
        m0_err  = m0_ack && err_q;
        m1_err  = m1_ack && err_q;
        m0_rd   = m0_ack ? rd_exec : 32'h0;
        m1_rd   = m1_ack ? rd_exec : 32'h0;
    end

endmodule
